// File: rtl/aes_pkg.sv
// Shared types and encodings for the AES cipher sequencers: FSM states, stage steps,
// datapath source-mux codes and round counts per key size.
package aes_pkg;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    typedef enum logic [2:0] {
        STEP_ARK0 = 3'd0,
        STEP_ISR  = 3'd1,
        STEP_ISB  = 3'd2,
        STEP_ARK  = 3'd3,
        STEP_IMC  = 3'd4
    } step_e;

    localparam logic [1:0] SRC_CT      = 2'd0;
    localparam logic [1:0] SRC_ISR     = 2'd1;
    localparam logic [1:0] SRC_ISB     = 2'd2;
    localparam logic [1:0] SRC_ARK_IMC = 2'd3;

    // Bit positions of each stage in the packed enable / valid vectors.
    localparam int STG_ISR = 0;
    localparam int STG_ISB = 1;
    localparam int STG_ARK = 2;
    localparam int STG_IMC = 3;

    function automatic logic [3:0] step_stage_mask(step_e s);
        logic [3:0] m;
        m = 4'b0000;
        case (s)
            STEP_ARK0, STEP_ARK: m[STG_ARK] = 1'b1;
            STEP_ISR:            m[STG_ISR] = 1'b1;
            STEP_ISB:            m[STG_ISB] = 1'b1;
            STEP_IMC:            m[STG_IMC] = 1'b1;
            default:             m = 4'b0000;
        endcase
        return m;
    endfunction

    // Each stage consumes the output of the stage that ran before it.
    function automatic logic [1:0] step_src(step_e s);
        logic [1:0] r;
        case (s)
            STEP_ARK0: r = SRC_CT;
            STEP_ISR:  r = SRC_ARK_IMC;
            STEP_ISB:  r = SRC_ISR;
            STEP_ARK:  r = SRC_ISB;
            STEP_IMC:  r = SRC_ARK_IMC;
            default:   r = SRC_CT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_stage_watchdog.sv
// Per-stage timeout counter shared by the encrypt and decrypt sequencers. The clear
// cycle (the issue cycle) counts as the first elapsed cycle.
module aes_stage_watchdog #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= CNT_W'(1);
        end else if (en && !timeout) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Fires in the wait cycle whose increment would bring the count to TIMEOUT.
    assign timeout = en && ((cnt + CNT_W'(1)) == CNT_W'(TIMEOUT));

endmodule

// File: rtl/aes_inv_round_seq.sv
// AES inverse-cipher stage sequencer: issues ARK(NR), then (ISR,ISB,ARK,IMC) per round,
// then ISR,ISB,ARK(0), one stage at a time, waiting on each stage's valid.
module aes_inv_round_seq
    import aes_pkg::*;
#(
    parameter int NR      = NR_AES128,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       isr_valid,
    input  logic       isb_valid,
    input  logic       ark_valid,
    input  logic       imc_valid,
    output logic       isr_en,
    output logic       isb_en,
    output logic       ark_en,
    output logic       imc_en,
    output logic [3:0] key_idx,
    output logic [1:0] src_sel,
    output logic       busy,
    output logic       done,
    output logic       err
);

    seq_state_e state;
    step_e      step;
    step_e      nxt_step;
    logic [3:0] rnd;
    logic [3:0] nxt_rnd;
    logic [3:0] stage_en;
    logic [3:0] stage_valid;
    logic       stage_hit;
    logic       last_op;
    logic       wd_clr;
    logic       wd_en;
    logic       wd_timeout;

    assign stage_valid = {imc_valid, ark_valid, isb_valid, isr_valid};
    // Only the valid of the stage currently in flight is honoured.
    assign stage_hit   = |(step_stage_mask(step) & stage_valid);
    assign last_op     = (step == STEP_ARK) && (rnd == 4'd0);
    assign wd_clr      = (state == ST_ISSUE);
    assign wd_en       = (state == ST_WAIT);

    // rnd tracks the round key the next ARK uses; it drops after each IMC.
    always_comb begin
        nxt_step = step;
        nxt_rnd  = rnd;
        case (step)
            STEP_ARK0: begin
                nxt_step = STEP_ISR;
                nxt_rnd  = 4'(NR - 1);
            end
            STEP_ISR: nxt_step = STEP_ISB;
            STEP_ISB: nxt_step = STEP_ARK;
            STEP_ARK: nxt_step = STEP_IMC;
            STEP_IMC: begin
                nxt_step = STEP_ISR;
                nxt_rnd  = rnd - 4'd1;
            end
            default: nxt_step = STEP_ARK0;
        endcase
    end

    aes_stage_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .timeout (wd_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            step     <= STEP_ARK0;
            rnd      <= '0;
            stage_en <= '0;
            key_idx  <= '0;
            src_sel  <= SRC_CT;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else if (abort) begin
            state    <= ST_IDLE;
            stage_en <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_ISSUE;
                        busy     <= 1'b1;
                        err      <= 1'b0;
                        step     <= STEP_ARK0;
                        rnd      <= 4'(NR);
                        stage_en <= step_stage_mask(STEP_ARK0);
                        src_sel  <= step_src(STEP_ARK0);
                        key_idx  <= 4'(NR);
                    end
                end
                ST_ISSUE: begin
                    stage_en <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (stage_hit) begin
                        if (last_op) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= ST_ISSUE;
                            step     <= nxt_step;
                            rnd      <= nxt_rnd;
                            stage_en <= step_stage_mask(nxt_step);
                            src_sel  <= step_src(nxt_step);
                            if (nxt_step == STEP_ARK) begin
                                key_idx <= nxt_rnd;
                            end
                        end
                    end else if (wd_timeout) begin
                        state <= ST_IDLE;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign isr_en = stage_en[STG_ISR];
    assign isb_en = stage_en[STG_ISB];
    assign ark_en = stage_en[STG_ARK];
    assign imc_en = stage_en[STG_IMC];

endmodule

// File: tb/tb_aes_inv_round_seq.sv
// Bench for aes_inv_round_seq: stub stages with per-op delays, an op-list reference
// model feeding an expected-event queue, and a negedge monitor that pops and compares.
module tb_aes_inv_round_seq;

    localparam int NR      = 10;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;
    localparam int EW      = 19;

    localparam int K_ISR  = 0;
    localparam int K_ISB  = 1;
    localparam int K_ARK  = 2;
    localparam int K_IMC  = 3;
    localparam int K_DONE = 4;
    localparam int K_ERR  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    wire        isr_valid, isb_valid, ark_valid, imc_valid;
    logic       isr_en, isb_en, ark_en, imc_en;
    logic [3:0] key_idx;
    logic [1:0] src_sel;
    logic       busy, done, err;

    logic [3:0] stub_v = 4'b0;
    logic [3:0] junk_v = 4'b0;
    assign {imc_valid, ark_valid, isb_valid, isr_valid} = stub_v | junk_v;

    aes_inv_round_seq #(.NR(NR), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .isr_valid(isr_valid), .isb_valid(isb_valid),
        .ark_valid(ark_valid), .imc_valid(imc_valid),
        .isr_en(isr_en), .isb_en(isb_en), .ark_en(ark_en), .imc_en(imc_en),
        .key_idx(key_idx), .src_sel(src_sel),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int start_cyc = 0;
    bit mon_on = 1'b0;
    logic [EW-1:0] exp_q[$];

    // Stub configuration, indexed by stage-operation number within a run.
    int dly[64];
    bit spur[64];
    int drop_k = -1;

    function automatic logic [EW-1:0] mk_ev(input int kind, input int key, input int src, input int t);
        return {3'(kind), 4'(key), 2'(src), 10'(t)};
    endfunction

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference model: op list from the round structure, timing from stub delays.
    task automatic build_expected(input int cut);
        int kinds[$];
        int keys[$];
        int t;
        int src;
        kinds.push_back(K_ARK); keys.push_back(NR);
        for (int r = NR - 1; r >= 1; r--) begin
            kinds.push_back(K_ISR); keys.push_back(0);
            kinds.push_back(K_ISB); keys.push_back(0);
            kinds.push_back(K_ARK); keys.push_back(r);
            kinds.push_back(K_IMC); keys.push_back(0);
        end
        kinds.push_back(K_ISR); keys.push_back(0);
        kinds.push_back(K_ISB); keys.push_back(0);
        kinds.push_back(K_ARK); keys.push_back(0);
        t = 1;
        for (int k = 0; k < kinds.size(); k++) begin
            if (t > cut) return;
            case (kinds[k])
                K_ISR:   src = 3;
                K_ISB:   src = 1;
                K_ARK:   src = (k == 0) ? 0 : 2;
                default: src = 3;
            endcase
            exp_q.push_back(mk_ev(kinds[k], keys[k], src, t));
            if (k == drop_k) begin
                if (t + TIMEOUT <= cut) exp_q.push_back(mk_ev(K_ERR, 0, 0, t + TIMEOUT));
                return;
            end
            t = t + dly[k] + 1;
        end
        if (t <= cut) exp_q.push_back(mk_ev(K_DONE, 0, 0, t));
    endtask

    // Stage stubs: raise the issued stage's valid dly[k] cycles after its enable.
    int s_k;
    int op_k = 0;
    logic [3:0] s_ens, s_wrong;
    initial begin
        forever begin
            @(negedge clk);
            if (start && !busy) op_k = 0;
            s_ens = {imc_en, ark_en, isb_en, isr_en};
            if (s_ens != 4'b0) begin
                s_k = op_k;
                op_k++;
                if (s_k != drop_k && s_k < 64) begin
                    s_wrong = (s_ens == 4'b0100) ? 4'b0001 : {s_ens[2:0], s_ens[3]};
                    for (int i = 0; i < dly[s_k]; i++) begin
                        @(posedge clk); #1;
                        if (i == 0 && spur[s_k]) stub_v = stub_v | s_wrong;
                        if (i == dly[s_k] - 1) stub_v = stub_v | s_ens;
                    end
                    @(posedge clk); #1;
                    stub_v = 4'b0;
                end
            end
        end
    end

    task automatic compare_ev(input logic [EW-1:0] got);
        logic [EW-1:0] e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind=%0d key=%0d src=%0d cyc=%0d, expected no event",
                     got[18:16], got[15:12], got[11:10], got[9:0]);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                fails++;
                $display("FAIL event: got kind=%0d key=%0d src=%0d cyc=%0d, expected kind=%0d key=%0d src=%0d cyc=%0d",
                         got[18:16], got[15:12], got[11:10], got[9:0],
                         e[18:16], e[15:12], e[11:10], e[9:0]);
            end
        end
    endtask

    // Monitor: every enable, done pulse and err rise is one observed event.
    logic [3:0] m_ens;
    int m_rel;
    int m_kind;
    logic err_prev = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                m_ens = {imc_en, ark_en, isb_en, isr_en};
                m_rel = cyc - start_cyc;
                if ($countones(m_ens) > 1) begin
                    tests++;
                    fails++;
                    $display("FAIL onehot_en: got enables %b expected at most one", m_ens);
                end
                if (m_ens != 4'b0) begin
                    m_kind = m_ens[0] ? K_ISR : m_ens[1] ? K_ISB : m_ens[2] ? K_ARK : K_IMC;
                    compare_ev(mk_ev(m_kind, ark_en ? int'(key_idx) : 0, int'(src_sel), m_rel));
                end
                if (done) begin
                    compare_ev(mk_ev(K_DONE, 0, 0, m_rel));
                    check("busy_at_done", int'(busy), 0);
                end
                if (err && !err_prev) begin
                    compare_ev(mk_ev(K_ERR, 0, 0, m_rel));
                    check("busy_at_err", int'(busy), 0);
                end
                err_prev = err;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"}, int'({imc_en, ark_en, isb_en, isr_en}), 0);
        check({tag, "_key_idx"}, int'(key_idx), 0);
        check({tag, "_src_sel"}, int'(src_sel), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_err"}, int'(err), 0);
    endtask

    task automatic set_cfg(input int d, input bit s);
        for (int i = 0; i < 64; i++) begin
            dly[i] = d;
            spur[i] = s;
        end
        drop_k = -1;
    endtask

    // One decrypt run; re_at/abort_at/rst_at are run-relative cycles, 0 meaning unused.
    task automatic do_run(input string tag, input int re_at, input int abort_at, input int rst_at);
        int cut;
        cut = 1000;
        if (abort_at > 0 && abort_at < cut) cut = abort_at;
        if (rst_at > 0 && rst_at < cut) cut = rst_at;
        build_expected(cut);
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_c1"}, int'(busy), 1);
        check({tag, "_err_c1"}, int'(err), 0);
        for (int c = 1; c < 600; c++) begin
            if (exp_q.size() == 0 && c > re_at && c > abort_at && c > rst_at) break;
            if (c == re_at) start = 1'b1;
            if (c == abort_at) abort = 1'b1;
            if (c == rst_at) rst = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            rst = 1'b0;
            if (c == abort_at) begin
                check({tag, "_abort_busy"}, int'(busy), 0);
                check({tag, "_abort_en"}, int'({imc_en, ark_en, isb_en, isr_en}), 0);
                check({tag, "_abort_err"}, int'(err), 0);
            end
            if (c == rst_at) begin
                check_reset_outputs({tag, "_rst"});
                junk_v = 4'hF;
                repeat (3) begin
                    @(posedge clk); #1;
                    check({tag, "_en_after_rst"}, int'({imc_en, ark_en, isb_en, isr_en}), 0);
                end
                junk_v = 4'h0;
            end
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_drain: %0d expected events never seen within budget", tag, exp_q.size());
            exp_q.delete();
        end
        repeat (8) @(posedge clk);
        #1;
        check({tag, "_idle_busy"}, int'(busy), 0);
    endtask

    initial begin
        set_cfg(1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        mon_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        do_run("nominal", 0, 0, 0);

        dly[18] = 3;
        do_run("slow_isb_r5", 0, 0, 0);

        set_cfg(1, 1'b0);
        drop_k = 4;
        do_run("imc_timeout", 0, 0, 0);
        check("err_sticky", int'(err), 1);

        drop_k = -1;
        do_run("recover", 0, 0, 0);

        set_cfg(1, 1'b0);
        for (int k = 0; k < 40; k++) begin
            if (k == 0 || (k % 4) == 3) begin
                dly[k] = 3;
                spur[k] = 1'b1;
            end
        end
        do_run("spurious", 0, 0, 0);

        set_cfg(1, 1'b0);
        do_run("restart_abort", 20, 30, 0);
        do_run("after_abort", 0, 0, 0);

        // abort wins over start while idle
        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("abort_vs_start_busy", int'(busy), 0);
        check("abort_vs_start_en", int'({imc_en, ark_en, isb_en, isr_en}), 0);
        repeat (3) @(posedge clk);
        #1;

        repeat (6) begin
            for (int i = 0; i < 64; i++) begin
                dly[i] = $urandom_range(1, 3);
                spur[i] = 1'($urandom_range(0, 1));
            end
            drop_k = -1;
            do_run("random", 0, 0, 0);
        end

        set_cfg(1, 1'b0);
        do_run("reset_mid", 0, 0, 40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, %0d tests run", tests);
        $fatal(1, "bench timeout");
    end

endmodule
